// File: rtl/super_pkg.sv
// rtl/super_pkg.sv - shared register width, tag position and sweep state type
package super_pkg;

  localparam int RegW   = 32;
  localparam int TagBit = RegW - 1;

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_SCAN = 2'd1,
    RF_REQ  = 2'd2,
    RF_WAIT = 2'd3
  } rf_sweep_state_e;

endpackage

// File: rtl/regfile_rvk_sweep.sv
// rtl/regfile_rvk_sweep.sv - walks the register file, asks for revocation of tagged entries
module regfile_rvk_sweep
  import super_pkg::*;
#(
  parameter int NRegs     = 32,
  parameter bit CHERIoTEn = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [NRegs-1:0] tag_i,
  input  logic [NRegs-1:0] touch_i,
  input  logic             rvk_gnt_i,
  input  logic             rvk_valid_i,
  input  logic             rvk_revoked_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rvk_req_o,
  output logic [NRegs-1:0] clr_o,
  output logic [4:0]       idx_o
);

  localparam logic [4:0] LastIdx = 5'(NRegs - 1);

  rf_sweep_state_e state_q;
  logic [4:0]      idx_q;
  logic            stale_q;
  logic            done_q;
  logic            stale_now;
  logic            revoke_hit;

  // A touch in the response cycle itself also invalidates the response.
  assign stale_now  = stale_q | touch_i[idx_q];
  assign revoke_hit = (state_q == RF_WAIT) && rvk_valid_i && rvk_revoked_i && !stale_now;

  always_comb begin
    clr_o = '0;
    if (revoke_hit) clr_o[idx_q] = 1'b1;
  end

  assign busy_o    = (state_q != RF_IDLE);
  assign rvk_req_o = (state_q == RF_REQ);
  assign done_o    = done_q;
  assign idx_o     = idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      stale_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RF_IDLE: begin
          if (start_i && CHERIoTEn) begin
            idx_q   <= 5'd1;
            stale_q <= 1'b0;
            state_q <= RF_SCAN;
          end
        end
        RF_SCAN: begin
          stale_q <= touch_i[idx_q];
          if (tag_i[idx_q]) begin
            state_q <= RF_REQ;
          end else if (idx_q == LastIdx) begin
            done_q  <= 1'b1;
            state_q <= RF_IDLE;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        RF_REQ: begin
          stale_q <= stale_now;
          if (rvk_gnt_i) state_q <= RF_WAIT;
        end
        RF_WAIT: begin
          if (rvk_valid_i) begin
            stale_q <= 1'b0;
            if (stale_now) begin
              state_q <= RF_SCAN;
            end else if (idx_q == LastIdx) begin
              done_q  <= 1'b1;
              state_q <= RF_IDLE;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= RF_SCAN;
            end
          end else begin
            stale_q <= stale_now;
          end
        end
        default: state_q <= RF_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with capability tags and revocation sweep
module regfile_mp
  import super_pkg::*;
#(
  parameter int NRegs     = 32,
  parameter int NWrPorts  = 3,
  parameter int NRdPorts  = 4,
  parameter bit CHERIoTEn = 1,
  parameter bit WrBypass  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NRdPorts*5-1:0]    raddr_i,
  output logic [NRdPorts*RegW-1:0] rdata_o,
  input  logic [NWrPorts*5-1:0]    waddr_i,
  input  logic [NWrPorts*RegW-1:0] wdata_i,
  input  logic [NWrPorts-1:0]      we_i,
  input  logic                     trvk_en_i,
  input  logic                     trvk_clrtag_i,
  input  logic [4:0]               trvk_addr_i,
  input  logic                     sweep_start_i,
  output logic                     sweep_busy_o,
  output logic                     sweep_done_o,
  output logic                     rvk_req_o,
  output logic [RegW-2:0]          rvk_data_o,
  input  logic                     rvk_gnt_i,
  input  logic                     rvk_valid_i,
  input  logic                     rvk_revoked_i
);

  localparam logic [5:0] NRegsW = 6'(NRegs);

  logic [RegW-1:0]  rf_q   [NRegs];
  logic [RegW-1:0]  rf_d   [NRegs];
  logic [RegW-1:0]  wr_val [NRegs];
  logic [NRegs-1:0] wr_hit;
  logic [NRegs-1:0] ext_clr;
  logic [NRegs-1:0] sweep_clr;
  logic [NRegs-1:0] tags;
  logic [NRegs-1:0] touch;
  logic [4:0]       sweep_idx;
  logic [4:0]       ra;
  logic             ext_en;

  assign ext_en = CHERIoTEn && trvk_en_i && trvk_clrtag_i;

  // Ascending port order lets the highest enabled port win; the external clear masks the winner.
  always_comb begin
    for (int r = 0; r < NRegs; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      for (int p = 0; p < NWrPorts; p++) begin
        if (we_i[p] && (waddr_i[p*5 +: 5] == 5'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wdata_i[p*RegW +: RegW];
        end
      end
      ext_clr[r] = ext_en && (trvk_addr_i == 5'(r));
      if (ext_clr[r]) wr_val[r][TagBit] = 1'b0;
      tags[r]  = rf_q[r][TagBit];
      touch[r] = wr_hit[r] | ext_clr[r];
    end
  end

  // A port write overrides a sweep clear of the same register.
  always_comb begin
    for (int r = 0; r < NRegs; r++) begin
      rf_d[r] = rf_q[r];
      if (r == 0) begin
        rf_d[r] = '0;
      end else if (wr_hit[r]) begin
        rf_d[r] = wr_val[r];
      end else if (ext_clr[r] || sweep_clr[r]) begin
        rf_d[r][TagBit] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NRegs; r++) rf_q[r] <= '0;
    end else begin
      for (int r = 0; r < NRegs; r++) rf_q[r] <= rf_d[r];
    end
  end

  always_comb begin
    rdata_o = '0;
    ra      = '0;
    for (int p = 0; p < NRdPorts; p++) begin
      ra = raddr_i[p*5 +: 5];
      if ((ra != 5'd0) && ({1'b0, ra} < NRegsW)) begin
        if (WrBypass && wr_hit[ra]) rdata_o[p*RegW +: RegW] = wr_val[ra];
        else                        rdata_o[p*RegW +: RegW] = rf_q[ra];
      end
    end
  end

  assign rvk_data_o = rf_q[sweep_idx][RegW-2:0];

  regfile_rvk_sweep #(
    .NRegs     (NRegs),
    .CHERIoTEn (CHERIoTEn)
  ) u_sweep (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (sweep_start_i),
    .tag_i         (tags),
    .touch_i       (touch),
    .rvk_gnt_i     (rvk_gnt_i),
    .rvk_valid_i   (rvk_valid_i),
    .rvk_revoked_i (rvk_revoked_i),
    .busy_o        (sweep_busy_o),
    .done_o        (sweep_done_o),
    .rvk_req_o     (rvk_req_o),
    .clr_o         (sweep_clr),
    .idx_o         (sweep_idx)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and randomized checks of regfile_mp against a behavioural model
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [19:0]  raddr;
  logic [127:0] rdata, rdata_bp;
  logic [14:0]  waddr;
  logic [95:0]  wdata;
  logic [2:0]   we;
  logic         trvk_en, trvk_clr;
  logic [4:0]   trvk_addr;
  logic         start, gnt, valid, revoked;
  logic         busy, done, req, busy_b, done_b, req_b;
  logic [30:0]  rdat, rdat_b;

  int tests = 0;
  int fails = 0;

  logic [31:0] model  [32];
  logic [31:0] nxt    [32];
  logic        wr_mark[32];

  always #5 clk = ~clk;

  regfile_mp #(.NRegs(32), .WrBypass(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .trvk_en_i(trvk_en), .trvk_clrtag_i(trvk_clr), .trvk_addr_i(trvk_addr),
    .sweep_start_i(start), .sweep_busy_o(busy), .sweep_done_o(done),
    .rvk_req_o(req), .rvk_data_o(rdat), .rvk_gnt_i(gnt),
    .rvk_valid_i(valid), .rvk_revoked_i(revoked)
  );

  regfile_mp #(.NRegs(24), .WrBypass(1)) dut_bp (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_bp),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .trvk_en_i(trvk_en), .trvk_clrtag_i(trvk_clr), .trvk_addr_i(trvk_addr),
    .sweep_start_i(start), .sweep_busy_o(busy_b), .sweep_done_o(done_b),
    .rvk_req_o(req_b), .rvk_data_o(rdat_b), .rvk_gnt_i(gnt),
    .rvk_valid_i(valid), .rvk_revoked_i(revoked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; trvk_en = 1'b0; trvk_clr = 1'b0; trvk_addr = '0;
    start = 1'b0; gnt = 1'b0; valid = 1'b0; revoked = 1'b0;
  endtask

  // Next-state of the architectural registers from the current inputs.
  task automatic calc_next();
    logic [4:0] a;
    for (int i = 0; i < 32; i++) begin nxt[i] = model[i]; wr_mark[i] = 1'b0; end
    for (int p = 0; p < 3; p++) begin
      if (we[p]) begin
        a = waddr[p*5 +: 5];
        nxt[a] = wdata[p*32 +: 32];
        wr_mark[a] = 1'b1;
      end
    end
    if (trvk_en && trvk_clr) nxt[trvk_addr][31] = 1'b0;
    nxt[0] = '0;
  endtask

  task automatic commit();
    for (int i = 0; i < 32; i++) model[i] = nxt[i];
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    we = 3'b001; waddr[4:0] = a; wdata[31:0] = d;
    calc_next(); step(); commit();
    we = '0;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr[4:0] = a;
    #1;
    chk(tag, rdata[31:0], exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, ndone, done_c, k;
    logic pend, pend_rev;
    logic [30:0] reqd [2];
    logic [4:0]  a;
    logic [31:0] exp_bp;

    idle();
    raddr = '0; waddr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    reqd[0] = '0; reqd[1] = '0;

    // Reset state
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busy_bp", {31'd0, busy_b}, 32'd0);
    rst_n = 1'b1;
    step();
    rdchk("rst_x5", 5'd5, 32'h0);

    // Same-cycle writes from ports 0 and 2 to x5: port 2 wins
    we = 3'b101;
    waddr = {5'd5, 5'd0, 5'd5};
    wdata = {32'h2, 32'h0, 32'h1};
    calc_next(); step(); commit(); idle();
    rdchk("x5_port_prio", 5'd5, 32'h2);
    wr1(5'd0, 32'hFFFF);
    rdchk("x0_zero", 5'd0, 32'h0);
    chk("x0_zero_bp", rdata_bp[31:0], 32'h0);

    // Bypass of a write whose tag is cleared in the same cycle
    we = 3'b001; waddr[4:0] = 5'd7; wdata[31:0] = 32'h8000_0001;
    trvk_en = 1'b1; trvk_clr = 1'b1; trvk_addr = 5'd7;
    raddr[4:0] = 5'd7;
    #1;
    chk("bypass_masked", rdata_bp[31:0], 32'h0000_0001);
    chk("nobypass_old", rdata[31:0], 32'h0);
    calc_next(); step(); commit(); idle();
    rdchk("x7_stored", 5'd7, 32'h0000_0001);
    chk("x7_stored_bp", rdata_bp[31:0], 32'h0000_0001);

    // Randomized writes, collisions and external clears
    for (int it = 0; it < 150; it++) begin
      for (int p = 0; p < 3; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        waddr[p*5 +: 5] = (it % 3 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wdata[p*32 +: 32] = $urandom;
      end
      trvk_en   = ($urandom_range(0, 3) == 0);
      trvk_clr  = 1'($urandom_range(0, 1));
      trvk_addr = (it % 2 == 1) ? waddr[4:0] : 5'($urandom_range(0, 31));
      raddr[4:0]   = waddr[4:0];
      raddr[9:5]   = waddr[9:5];
      raddr[14:10] = 5'($urandom_range(0, 31));
      raddr[19:15] = 5'($urandom_range(20, 31));
      calc_next();
      #1;
      for (int p = 0; p < 4; p++) begin
        a = raddr[p*5 +: 5];
        chk("rand_rd", rdata[p*32 +: 32], model[a]);
        exp_bp = (a >= 5'd24) ? 32'h0 : (wr_mark[a] ? nxt[a] : model[a]);
        chk("rand_rd_bp", rdata_bp[p*32 +: 32], exp_bp);
      end
      step(); commit();
    end
    idle();
    for (int r = 0; r < 32; r++) rdchk("rand_final", 5'(r), model[r]);

    // Only x3 and x9 tagged
    for (int r = 1; r < 32; r++) wr1(5'(r), (32'(r) * 32'h111) & 32'h7FFF_FFFF);
    wr1(5'd3, 32'h8000_0033);
    wr1(5'd9, 32'h8000_0099);

    start = 1'b1; step(); start = 1'b0;
    nreq = 0; ndone = 0; done_c = 0; pend = 1'b0; pend_rev = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (done) begin ndone++; done_c = c; end
      valid   = pend;
      revoked = pend_rev;
      gnt     = req;
      pend    = req;
      pend_rev = req && (rdat == 31'h33);
      if (req) begin
        if (nreq < 2) reqd[nreq] = rdat;
        nreq++;
      end
      step();
    end
    idle();
    model[3][31] = 1'b0;
    chk("sweep_nreq", 32'(nreq), 32'd2);
    chk("sweep_req0", {1'b0, reqd[0]}, 32'h33);
    chk("sweep_req1", {1'b0, reqd[1]}, 32'h99);
    chk("sweep_ndone", 32'(ndone), 32'd1);
    chk("sweep_done_cycle", 32'(done_c), 32'd36);
    chk("sweep_busy_end", {31'd0, busy}, 32'd0);
    rdchk("sweep_x3", 5'd3, 32'h0000_0033);
    rdchk("sweep_x9", 5'd9, 32'h8000_0099);

    // Request held without grant, then a write to the swept register while waiting
    wr1(5'd3, 32'h8000_0033);
    start = 1'b1; step(); start = 1'b0;
    for (k = 0; k < 20 && !req; k++) step();
    chk("req_seen", {31'd0, req}, 32'd1);
    chk("req_data", {1'b0, rdat}, 32'h33);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("hold_req", {31'd0, req}, 32'd1);
      chk("hold_data", {1'b0, rdat}, 32'h33);
    end
    gnt = 1'b1; step(); gnt = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("wait_noreq", {31'd0, req}, 32'd0);
    wr1(5'd3, 32'h8000_0555);
    valid = 1'b1; revoked = 1'b1; step(); valid = 1'b0; revoked = 1'b0;
    rdchk("stale_x3_kept", 5'd3, 32'h8000_0555);
    for (k = 0; k < 10 && !req; k++) step();
    chk("rereq_seen", {31'd0, req}, 32'd1);
    chk("rereq_data", {1'b0, rdat}, 32'h555);

    // Reset while waiting, then a late response
    gnt = 1'b1; step(); gnt = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_req", {31'd0, req}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    step();
    valid = 1'b1; revoked = 1'b1; step(); valid = 1'b0; revoked = 1'b0;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("late_rsp_idle", 32'(ndone), 32'd0);
    rdchk("late_rsp_x3", 5'd3, model[3]);
    rdchk("late_rsp_x9", 5'd9, model[9]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter NRegs, default 32, number of architectural registers (2..32); register 0 hard-wired to zero.
REQ-002 SHALL have parameter NWrPorts, default 3, number of write ports (1..4).
REQ-003 SHALL have parameter NRdPorts, default 4, number of read ports (1..6).
REQ-004 SHALL have parameter CHERIoTEn, default 1, enabling all tag-clearing and sweep logic; when 0 the tag bit is stored as written and rvk_req_o is tied 0.
REQ-005 SHALL have parameter WrBypass, default 0, enabling same-cycle write-to-read forwarding.
REQ-006 SHALL have ports clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports raddr_i  in  NRdPorts x 5  read addresses; rdata_o  out  NRdPorts x RegW  read data.
REQ-008 SHALL have ports waddr_i  in  NWrPorts x 5; wdata_i  in  NWrPorts x RegW; we_i  in  NWrPorts  write enables.
REQ-009 SHALL have ports trvk_en_i, trvk_clrtag_i  in  1; trvk_addr_i  in  5  external tag-clear request.
REQ-010 SHALL have ports sweep_start_i  in  1; sweep_busy_o  out  1; sweep_done_o  out  1 (single-cycle pulse).
REQ-011 SHALL have ports rvk_req_o  out  1; rvk_data_o  out  RegW-1  untagged contents of swept register; rvk_gnt_i  in  1; rvk_valid_i  in  1; rvk_revoked_i  in  1.

Function
REQ-012 Tag SHALL be bit RegW-1 of each register; a tag clear SHALL zero only that bit.
REQ-013 Reads SHALL be combinational; raddr 0 SHALL return all-zero; addresses >= NRegs SHALL return all-zero.
REQ-014 Writes SHALL take effect at the next clock edge; for equal addresses the highest-index enabled port SHALL win; writes to address 0 SHALL be dropped.
REQ-015 An external clear (trvk_en_i & trvk_clrtag_i) matching a register SHALL clear the tag of that register whether or not it is written in the same cycle.
REQ-016 With WrBypass=1, a read of an address written this cycle SHALL return the winning write data with REQ-015 masking applied; with WrBypass=0 the read SHALL return the old value.
REQ-017 Sweep FSM states SHALL be IDLE, SCAN, REQ, WAIT; sweep_busy_o SHALL be 1 in all states except IDLE.
REQ-018 IDLE: sweep_start_i SHALL load index 1 and go to SCAN; sweep_start_i while busy SHALL be ignored.
REQ-019 SCAN: a tagged register at index SHALL go to REQ; an untagged one SHALL increment the index; after index NRegs-1 the FSM SHALL pulse sweep_done_o and return to IDLE. Each SCAN step SHALL take one cycle.
REQ-020 REQ: rvk_req_o SHALL be 1 and rvk_data_o SHALL hold the current register bits [RegW-2:0], stable until rvk_gnt_i; on grant the FSM SHALL go to WAIT.
REQ-021 WAIT: on rvk_valid_i with rvk_revoked_i=1 the tag SHALL be cleared at that edge, then the index SHALL advance to SCAN; with rvk_revoked_i=0 the index SHALL advance without change.
REQ-022 A write or external clear to the swept index while in REQ or WAIT SHALL set a stale flag; the response SHALL then be discarded and SCAN SHALL re-examine the same index.
REQ-023 A port write on the same edge as a sweep clear of the same register SHALL win, with the stale rule applied.
REQ-024 rvk_valid_i outside WAIT and rvk_gnt_i outside REQ SHALL be ignored.

Reset
REQ-025 On reset all registers, index, and stale flag SHALL be 0; the FSM SHALL enter IDLE; rvk_req_o, sweep_busy_o, sweep_done_o SHALL be 0.
REQ-026 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; a late response after reset SHALL be ignored.

Structure
REQ-027 super_pkg SHALL hold the rf_sweep_state_e enum and the RegW/tag-bit constants.
REQ-028 The sweep FSM SHALL be the sub-module regfile_rvk_sweep, driving a one-hot clear vector and an index into regfile_mp.

Verification
REQ-029 Ports 0 and 2 write x5 with 0x1 and 0x2 in the same cycle -> x5 reads 0x2 next cycle; x0 write of 0xFFFF -> x0 reads 0.
REQ-030 WrBypass=1: write x7=0x8000_0001 (tag set) with trvk clear of x7 in the same cycle -> same-cycle read returns 0x0000_0001; the value is stored as 0x0000_0001.
REQ-031 Only x3 and x9 are tagged; sweep with x3 revoked and x9 not revoked -> exactly two requests, x3 tag 0, x9 tag 1, done pulse exactly one cycle after index 31.
REQ-032 Write x3 while in WAIT for x3, with revoked=1 -> new x3 value keeps its tag, and a second request for x3 is issued.
REQ-033 Hold rvk_gnt_i low 10 cycles -> rvk_req_o and rvk_data_o remain stable throughout.
REQ-034 Assert rst_ni low while in WAIT, then pulse rvk_valid_i -> FSM stays IDLE, no tag changes, and no done pulse.
